// File: rtl/bram_capture_pkg.sv
// Shared types and frame geometry for the BRAM frame capture stage and its readout partner.
// The default geometry here also sizes the readout BRAM (BRAM_DEPTH = FRAME_PIXELS).
package bram_capture_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } capture_state_t;

  localparam int FRAME_WIDTH_DEFAULT  = 320;
  localparam int FRAME_HEIGHT_DEFAULT = 240;
  localparam int FRAME_PIXELS         = FRAME_WIDTH_DEFAULT * FRAME_HEIGHT_DEFAULT;
  localparam int ADDR_WIDTH           = $clog2(FRAME_PIXELS);

endpackage

// File: rtl/bram_frame_capture.sv
// Captures exactly one camera frame into BRAM port A on request and holds it until the request drops.
// Optional running XOR checksum of written words: define BRAM_FRAME_CAPTURE_CHECKSUM_EN.
module bram_frame_capture
  import bram_capture_pkg::*;
#(
  parameter int BRAM_WIDTH   = 24,
  parameter int FRAME_WIDTH  = FRAME_WIDTH_DEFAULT,
  parameter int FRAME_HEIGHT = FRAME_HEIGHT_DEFAULT,
  parameter int HCOUNT_WIDTH = 11,
  parameter int VCOUNT_WIDTH = 10,
  localparam int AW = $clog2(FRAME_WIDTH * FRAME_HEIGHT)
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    capture_in,
  input  logic                    pixel_valid_in,
  input  logic [HCOUNT_WIDTH-1:0] hcount_in,
  input  logic [VCOUNT_WIDTH-1:0] vcount_in,
  input  logic [BRAM_WIDTH-1:0]   pixel_in,
  output logic [AW-1:0]           bram_addr_out,
  output logic [BRAM_WIDTH-1:0]   bram_data_out,
  output logic                    bram_we_out,
  output logic                    busy_out,
  output logic                    frame_ready_out,
  output logic [BRAM_WIDTH-1:0]   checksum_out
);

  capture_state_t state;

  logic          in_window;
  logic          at_origin;
  logic          at_last;
  logic          write_hit;
  logic [AW-1:0] pixel_addr;

  always_comb begin
    in_window  = pixel_valid_in
                 && (32'(hcount_in) < 32'(FRAME_WIDTH))
                 && (32'(vcount_in) < 32'(FRAME_HEIGHT));
    at_origin  = pixel_valid_in && (hcount_in == '0) && (vcount_in == '0);
    at_last    = in_window
                 && (32'(hcount_in) == 32'(FRAME_WIDTH - 1))
                 && (32'(vcount_in) == 32'(FRAME_HEIGHT - 1));
    // Only the frame origin may open a capture, so ARMED never starts mid-frame.
    write_hit  = ((state == ARMED) && at_origin) || ((state == CAPTURE) && in_window);
    pixel_addr = AW'(32'(vcount_in) * 32'(FRAME_WIDTH) + 32'(hcount_in));
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state         <= IDLE;
      bram_we_out   <= 1'b0;
      bram_addr_out <= '0;
      bram_data_out <= '0;
    end else begin
      bram_we_out <= 1'b0;
      if (!capture_in) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: state <= ARMED;
          ARMED, CAPTURE: begin
            if (write_hit) begin
              bram_we_out   <= 1'b1;
              bram_addr_out <= pixel_addr;
              bram_data_out <= pixel_in;
              state         <= at_last ? DONE : CAPTURE;
            end
          end
          DONE:    state <= DONE;
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign busy_out        = (state == ARMED) || (state == CAPTURE);
  assign frame_ready_out = (state == DONE);

`ifdef BRAM_FRAME_CAPTURE_CHECKSUM_EN
  logic [BRAM_WIDTH-1:0] checksum;

  // A write at the origin (first pixel or restart) reseeds the sum with that pixel.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      checksum <= '0;
    end else if (capture_in && write_hit) begin
      checksum <= (at_origin ? '0 : checksum) ^ pixel_in;
    end
  end

  assign checksum_out = checksum;
`else
  assign checksum_out = '0;
`endif

endmodule
